// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Owns the single regfile write port. After reset it optionally sweeps every
// register to INIT_VALUE, then arbitrates round-robin between the ALU (src0) and
// load (src1) writeback sources, each behind a one-entry holding buffer. It also
// reports pending-write hazards for the decode stage's rs/rt operands.
// Optional feature: define REGWB_R0_DISCARD_EN to drop writes to register 0
// (handshake still completes) and to never flag register 0 as busy.

module regfile_wb_arbiter #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter bit                    INIT_SWEEP = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  s0_valid,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0] s0_data,
    output logic                  s0_ready,

    input  logic                  s1_valid,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic                  s1_ready,

    input  logic [ADDR_WIDTH-1:0] rs_query,
    input  logic [ADDR_WIDTH-1:0] rt_query,
    output logic                  rs_busy,
    output logic                  rt_busy,

    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  init_done
);

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    localparam state_e ResetState = INIT_SWEEP ? StInit : StRun;

    // The sweep counter has one extra bit so "all addresses issued" is a
    // distinct value from the last address itself.
    localparam logic [ADDR_WIDTH:0] SweepEnd = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CntOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     init_cnt_q, init_cnt_d;

    logic                    h0_valid_q, h0_valid_d;
    logic [ADDR_WIDTH-1:0]   h0_addr_q, h0_addr_d;
    logic [DATA_WIDTH-1:0]   h0_data_q, h0_data_d;

    logic                    h1_valid_q, h1_valid_d;
    logic [ADDR_WIDTH-1:0]   h1_addr_q, h1_addr_d;
    logic [DATA_WIDTH-1:0]   h1_data_q, h1_data_d;

    // 0 = src0 was granted last, 1 = src1 was granted last
    logic                    rr_last_q, rr_last_d;

    logic                    wb_en_q, wb_en_d;
    logic [ADDR_WIDTH-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                    init_done_q, init_done_d;

    logic                    in_run;
    logic                    accept0, accept1;
    logic                    keep0, keep1;
    logic                    grant0, grant1;
    logic                    rs_query_ok, rt_query_ok;
    logic                    rs_hit, rt_hit;

    // Handshake: a source can only be accepted in RUN with an empty buffer.
    always_comb begin
        in_run   = (state_q == StRun);
        s0_ready = in_run & ~h0_valid_q;
        s1_ready = in_run & ~h1_valid_q;
        accept0  = s0_valid & s0_ready;
        accept1  = s1_valid & s1_ready;
    end

`ifdef REGWB_R0_DISCARD_EN
    // Register 0 is hardwired: accepted requests to it are dropped on the floor.
    always_comb begin
        keep0       = accept0 & (s0_addr != '0);
        keep1       = accept1 & (s1_addr != '0);
        rs_query_ok = (rs_query != '0);
        rt_query_ok = (rt_query != '0);
    end
`else
    // Register 0 behaves like any other register.
    always_comb begin
        keep0       = accept0;
        keep1       = accept1;
        rs_query_ok = 1'b1;
        rt_query_ok = 1'b1;
    end
`endif

    // Round-robin grant on the pre-edge buffer state; ties go to the source
    // that was not served last.
    always_comb begin
        grant0 = in_run & h0_valid_q & (~h1_valid_q | rr_last_q);
        grant1 = in_run & h1_valid_q & (~h0_valid_q | ~rr_last_q);
    end

    // Next-state for the sweep, holding buffers, arbiter pointer and write port.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        h0_valid_d  = h0_valid_q;
        h0_addr_d   = h0_addr_q;
        h0_data_d   = h0_data_q;
        h1_valid_d  = h1_valid_q;
        h1_addr_d   = h1_addr_q;
        h1_data_d   = h1_data_q;
        rr_last_d   = rr_last_q;
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        init_done_d = init_done_q;

        unique case (state_q)
            StInit: begin
                if (init_cnt_q == SweepEnd) begin
                    // Every address has been written; wb_addr/wb_data hold.
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end else begin
                    wb_en_d    = 1'b1;
                    wb_addr_d  = init_cnt_q[ADDR_WIDTH-1:0];
                    wb_data_d  = INIT_VALUE;
                    init_cnt_d = init_cnt_q + CntOne;
                end
            end

            StRun: begin
                // Drain: at most one buffer is granted per cycle.
                if (grant0) begin
                    wb_en_d    = 1'b1;
                    wb_addr_d  = h0_addr_q;
                    wb_data_d  = h0_data_q;
                    h0_valid_d = 1'b0;
                    rr_last_d  = 1'b0;
                end else if (grant1) begin
                    wb_en_d    = 1'b1;
                    wb_addr_d  = h1_addr_q;
                    wb_data_d  = h1_data_q;
                    h1_valid_d = 1'b0;
                    rr_last_d  = 1'b1;
                end

                // Fill: only possible into an empty buffer, so never collides
                // with the drain of the same buffer above.
                if (keep0) begin
                    h0_valid_d = 1'b1;
                    h0_addr_d  = s0_addr;
                    h0_data_d  = s0_data;
                end
                if (keep1) begin
                    h1_valid_d = 1'b1;
                    h1_addr_d  = s1_addr;
                    h1_data_d  = s1_data;
                end
            end

            default: begin
                state_d = ResetState;
            end
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ResetState;
            init_cnt_q  <= '0;
            h0_valid_q  <= 1'b0;
            h0_addr_q   <= '0;
            h0_data_q   <= '0;
            h1_valid_q  <= 1'b0;
            h1_addr_q   <= '0;
            h1_data_q   <= '0;
            rr_last_q   <= 1'b1;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            init_done_q <= ~INIT_SWEEP;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            h0_valid_q  <= h0_valid_d;
            h0_addr_q   <= h0_addr_d;
            h0_data_q   <= h0_data_d;
            h1_valid_q  <= h1_valid_d;
            h1_addr_q   <= h1_addr_d;
            h1_data_q   <= h1_data_d;
            rr_last_q   <= rr_last_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            init_done_q <= init_done_d;
        end
    end

    // Hazard flags: a query is busy while any held or in-flight write targets it.
    always_comb begin
        rs_hit = (h0_valid_q && (h0_addr_q == rs_query)) ||
                 (h1_valid_q && (h1_addr_q == rs_query)) ||
                 (wb_en_q    && (wb_addr_q == rs_query));
        rt_hit = (h0_valid_q && (h0_addr_q == rt_query)) ||
                 (h1_valid_q && (h1_addr_q == rt_query)) ||
                 (wb_en_q    && (wb_addr_q == rt_query));
        rs_busy = in_run & rs_query_ok & rs_hit;
        rt_busy = in_run & rt_query_ok & rt_hit;
    end

    // Output drive from the registered write port.
    always_comb begin
        wb_en     = wb_en_q;
        wb_addr   = wb_addr_q;
        wb_data   = wb_data_q;
        init_done = init_done_q;
    end

endmodule
